// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for 640x480@60 VGA. The geometry is set by the
// parameters. It produces the pixel position, the active-video flag, the
// h/v sync signals, line and frame strobes, a frame counter, and copies of
// active/hsync/vsync delayed to match a downstream pixel pipeline.
//
// Parameters:
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal geometry in pixels (total 800)
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical geometry in lines (total 525)
//   SYNC_POL    asserted level of hsync/vsync (0 = active-low)
//   PIPE_DELAY  enabled-cycle delay on the *_d outputs, 0..7
//   FRAME_W     frame_count width
//
// Ports:
//   clock        in   rising-edge pixel/system clock
//   resetn       in   synchronous active-low reset
//   enable       in   pixel advance qualifier
//   x, y         out  current pixel position (registered)
//   active       out  pixel lies inside the visible area
//   hsync/vsync  out  sync pulses at SYNC_POL level when asserted
//   line_start   out  x == 0
//   frame_start  out  x == 0 and y == 0
//   frame_count  out  frame index, wraps modulo 2^FRAME_W
//   active_d, hsync_d, vsync_d  out  the same signals PIPE_DELAY enabled
//                                    cycles later
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned FRAME_W    = 10
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               active_d,
  output logic               hsync_d,
  output logic               vsync_d
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All position comparisons are made in 11 bits, so the sums never overflow.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};
  localparam logic [FRAME_W-1:0] FRAME_ONES = {FRAME_W{1'b1}};

  logic [9:0]  x_nxt_s;
  logic [9:0]  y_nxt_s;
  logic        x_wrap_s;
  logic        frame_wrap_s;
  logic [10:0] x_ext_s;
  logic [10:0] y_ext_s;
  logic        active_nxt_s;
  logic        hsync_nxt_s;
  logic        vsync_nxt_s;
  logic        line_start_nxt_s;
  logic        frame_start_nxt_s;

  // Next raster position. The >= tests keep the counters in range even if
  // they ever start outside it.
  always_comb begin
    x_nxt_s      = x;
    y_nxt_s      = y;
    x_wrap_s     = 1'b0;
    frame_wrap_s = 1'b0;
    if ({1'b0, x} >= H_LAST) begin
      x_nxt_s  = 10'd0;
      x_wrap_s = 1'b1;
    end else begin
      x_nxt_s  = x + 10'd1;
      x_wrap_s = 1'b0;
    end
    if (x_wrap_s) begin
      if ({1'b0, y} >= V_LAST) begin
        y_nxt_s      = 10'd0;
        frame_wrap_s = 1'b1;
      end else begin
        y_nxt_s      = y + 10'd1;
        frame_wrap_s = 1'b0;
      end
    end else begin
      y_nxt_s      = y;
      frame_wrap_s = 1'b0;
    end
  end

  // Decode the flags for the *next* position, so that once registered they
  // line up with x/y with no skew.
  always_comb begin
    x_ext_s = {1'b0, x_nxt_s};
    y_ext_s = {1'b0, y_nxt_s};
    active_nxt_s = (x_ext_s < H_ACT_END) && (y_ext_s < V_ACT_END);
    if ((x_ext_s >= HS_START) && (x_ext_s < HS_END)) begin
      hsync_nxt_s = SYNC_ON;
    end else begin
      hsync_nxt_s = SYNC_OFF;
    end
    // y only moves on the x wrap, so vsync can only change when x becomes 0.
    if ((y_ext_s >= VS_START) && (y_ext_s < VS_END)) begin
      vsync_nxt_s = SYNC_ON;
    end else begin
      vsync_nxt_s = SYNC_OFF;
    end
    line_start_nxt_s  = (x_nxt_s == 10'd0);
    frame_start_nxt_s = (x_nxt_s == 10'd0) && (y_nxt_s == 10'd0);
  end

  // Counter and output registers. The reset state is the last pixel of a
  // frame, so the first enabled cycle wraps to pixel (0,0) of frame 0.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x           <= 10'(H_TOTAL - 1);
      y           <= 10'(V_TOTAL - 1);
      frame_count <= FRAME_ONES;
      active      <= 1'b0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      x           <= x_nxt_s;
      y           <= y_nxt_s;
      frame_count <= frame_wrap_s ? (frame_count + FRAME_ONE) : frame_count;
      active      <= active_nxt_s;
      hsync       <= hsync_nxt_s;
      vsync       <= vsync_nxt_s;
      line_start  <= line_start_nxt_s;
      frame_start <= frame_start_nxt_s;
    end
  end

  // Delay line for active/hsync/vsync. It advances only on enabled cycles,
  // so the delay is counted in pixels rather than clocks.
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign active_d = active;
      assign hsync_d  = hsync;
      assign vsync_d  = vsync;
    end else if (PIPE_DELAY == 1) begin : g_delay_one
      logic active_pipe_r;
      logic hsync_pipe_r;
      logic vsync_pipe_r;

      // Single-stage delay register.
      always_ff @(posedge clock) begin
        if (!resetn) begin
          active_pipe_r <= 1'b0;
          hsync_pipe_r  <= SYNC_OFF;
          vsync_pipe_r  <= SYNC_OFF;
        end else if (enable) begin
          active_pipe_r <= active;
          hsync_pipe_r  <= hsync;
          vsync_pipe_r  <= vsync;
        end
      end

      assign active_d = active_pipe_r;
      assign hsync_d  = hsync_pipe_r;
      assign vsync_d  = vsync_pipe_r;
    end else begin : g_delay_multi
      logic [PIPE_DELAY-1:0] active_pipe_r;
      logic [PIPE_DELAY-1:0] hsync_pipe_r;
      logic [PIPE_DELAY-1:0] vsync_pipe_r;

      // Multi-stage shift register. Bit 0 is the newest value and the top
      // bit is the oldest.
      always_ff @(posedge clock) begin
        if (!resetn) begin
          active_pipe_r <= {PIPE_DELAY{1'b0}};
          hsync_pipe_r  <= {PIPE_DELAY{SYNC_OFF}};
          vsync_pipe_r  <= {PIPE_DELAY{SYNC_OFF}};
        end else if (enable) begin
          active_pipe_r <= {active_pipe_r[PIPE_DELAY-2:0], active};
          hsync_pipe_r  <= {hsync_pipe_r[PIPE_DELAY-2:0], hsync};
          vsync_pipe_r  <= {vsync_pipe_r[PIPE_DELAY-2:0], vsync};
        end
      end

      assign active_d = active_pipe_r[PIPE_DELAY-1];
      assign hsync_d  = hsync_pipe_r[PIPE_DELAY-1];
      assign vsync_d  = vsync_pipe_r[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// Testbench for vga_timing_gen. It uses three instances:
//   dut_a: default 640x480 timing, PIPE_DELAY=2, active-low sync
//   dut_b: default timing, PIPE_DELAY=3, active-high sync
//   dut_c: reduced 16x12 geometry, PIPE_DELAY=0, so that whole frames fit
//          in a short run
// A scoreboard queue holds the expected outputs for each driven cycle. The
// values come from a closed-form model indexed by the count of enabled
// cycles since reset. Scenario tasks add targeted checks.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [9:0] fc;
    logic       ad;
    logic       hd;
    logic       vd;
  } out_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;

  always #5 clock = ~clock;

  logic [9:0] a_x, a_y, a_frame_count, b_x, b_y, b_frame_count, c_x, c_y, c_frame_count;
  logic a_active, a_hsync, a_vsync, a_line_start, a_frame_start, a_active_d, a_hsync_d, a_vsync_d;
  logic b_active, b_hsync, b_vsync, b_line_start, b_frame_start, b_active_d, b_hsync_d, b_vsync_d;
  logic c_active, c_hsync, c_vsync, c_line_start, c_frame_start, c_active_d, c_hsync_d, c_vsync_d;

  vga_timing_gen #(.PIPE_DELAY(2)) dut_a (
    .clock(clock), .resetn(resetn), .enable(enable),
    .x(a_x), .y(a_y), .active(a_active), .hsync(a_hsync), .vsync(a_vsync),
    .line_start(a_line_start), .frame_start(a_frame_start), .frame_count(a_frame_count),
    .active_d(a_active_d), .hsync_d(a_hsync_d), .vsync_d(a_vsync_d));

  vga_timing_gen #(.SYNC_POL(1'b1), .PIPE_DELAY(3)) dut_b (
    .clock(clock), .resetn(resetn), .enable(enable),
    .x(b_x), .y(b_y), .active(b_active), .hsync(b_hsync), .vsync(b_vsync),
    .line_start(b_line_start), .frame_start(b_frame_start), .frame_count(b_frame_count),
    .active_d(b_active_d), .hsync_d(b_hsync_d), .vsync_d(b_vsync_d));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
                   .SYNC_POL(1'b0), .PIPE_DELAY(0)) dut_c (
    .clock(clock), .resetn(resetn), .enable(enable),
    .x(c_x), .y(c_y), .active(c_active), .hsync(c_hsync), .vsync(c_vsync),
    .line_start(c_line_start), .frame_start(c_frame_start), .frame_count(c_frame_count),
    .active_d(c_active_d), .hsync_d(c_hsync_d), .vsync_d(c_vsync_d));

  int tests = 0;
  int failed = 0;
  longint n_en = 0;

  out_t q_a[$];
  out_t q_b[$];
  out_t q_c[$];
  out_t exp_a, exp_b, exp_c, got_a, got_b, got_c;

  // Undelayed outputs after n enabled cycles since reset (n <= 0 means reset state).
  function automatic out_t base(longint n, int ha, int hf, int hsw, int hb,
                                int va, int vf, int vsw, int vb, bit pol);
    out_t o;
    longint ht, vt, p, line, xx, yy;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    o = '0;
    if (n <= 0) begin
      o.x = 10'(ht - 1); o.y = 10'(vt - 1); o.fc = 10'h3ff;
      o.active = 1'b0; o.ls = 1'b0; o.fs = 1'b0; o.hs = ~pol; o.vs = ~pol;
    end else begin
      p = n - 1;
      xx = p % ht;
      line = p / ht;
      yy = line % vt;
      o.x = 10'(xx); o.y = 10'(yy); o.fc = 10'((line / vt) % 1024);
      o.active = (xx < ha) && (yy < va);
      o.hs = (xx >= ha + hf && xx < ha + hf + hsw) ? pol : ~pol;
      o.vs = (yy >= va + vf && yy < va + vf + vsw) ? pol : ~pol;
      o.ls = (xx == 0);
      o.fs = (xx == 0) && (yy == 0);
    end
    return o;
  endfunction

  function automatic out_t model(longint n, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit pol, int pd);
    out_t o, dly;
    o = base(n, ha, hf, hsw, hb, va, vf, vsw, vb, pol);
    dly = base(n - pd, ha, hf, hsw, hb, va, vf, vsw, vb, pol);
    o.ad = dly.active; o.hd = dly.hs; o.vd = dly.vs;
    return o;
  endfunction

  // Drive one clock of stimulus and queue the expected results for it.
  task automatic cycle(input logic rst_v, input logic en_v);
    resetn = rst_v;
    enable = en_v;
    if (!rst_v) n_en = 0;
    else if (en_v) n_en++;
    q_a.push_back(model(n_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2));
    q_b.push_back(model(n_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 3));
    q_c.push_back(model(n_en, 8, 2, 3, 3, 6, 2, 2, 2, 1'b0, 0));
    @(posedge clock);
    #2;
  endtask

  // Scoreboard: after each edge, pop the expected outputs and compare them with what the DUTs show.
  always @(posedge clock) begin
    #1;
    if (q_a.size() > 0) begin
      exp_a = q_a.pop_front();
      got_a = {a_x, a_y, a_active, a_hsync, a_vsync, a_line_start, a_frame_start,
               a_frame_count, a_active_d, a_hsync_d, a_vsync_d};
      tests++;
      if (got_a !== exp_a) begin
        failed++;
        $display("FAIL sb_a n=%0d: got %h expected %h", n_en, got_a, exp_a);
      end
    end
    if (q_b.size() > 0) begin
      exp_b = q_b.pop_front();
      got_b = {b_x, b_y, b_active, b_hsync, b_vsync, b_line_start, b_frame_start,
               b_frame_count, b_active_d, b_hsync_d, b_vsync_d};
      tests++;
      if (got_b !== exp_b) begin
        failed++;
        $display("FAIL sb_b n=%0d: got %h expected %h", n_en, got_b, exp_b);
      end
    end
    if (q_c.size() > 0) begin
      exp_c = q_c.pop_front();
      got_c = {c_x, c_y, c_active, c_hsync, c_vsync, c_line_start, c_frame_start,
               c_frame_count, c_active_d, c_hsync_d, c_vsync_d};
      tests++;
      if (got_c !== exp_c) begin
        failed++;
        $display("FAIL sb_c n=%0d: got %h expected %h", n_en, got_c, exp_c);
      end
    end
  end

  task automatic test_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    tests++;
    if (a_x !== 10'd799 || a_y !== 10'd524) begin
      failed++; $display("FAIL reset_xy: got %0d/%0d expected 799/524", a_x, a_y);
    end
    tests++;
    if (a_frame_count !== 10'h3ff) begin
      failed++; $display("FAIL reset_fc: got %h expected 3ff", a_frame_count);
    end
    tests++;
    if ({a_active, a_line_start, a_frame_start} !== 3'b000) begin
      failed++; $display("FAIL reset_flags: got %b expected 000", {a_active, a_line_start, a_frame_start});
    end
    tests++;
    if ({a_hsync, a_vsync, a_hsync_d, a_vsync_d, a_active_d} !== 5'b11110) begin
      failed++; $display("FAIL reset_sync_a: got %b expected 11110",
                         {a_hsync, a_vsync, a_hsync_d, a_vsync_d, a_active_d});
    end
    tests++;
    if ({b_hsync, b_vsync, b_hsync_d, b_vsync_d, b_active_d} !== 5'b00000) begin
      failed++; $display("FAIL reset_sync_b: got %b expected 00000",
                         {b_hsync, b_vsync, b_hsync_d, b_vsync_d, b_active_d});
    end
    cycle(1'b1, 1'b0);
    tests++;
    if (a_x !== 10'd799 || a_frame_start !== 1'b0) begin
      failed++; $display("FAIL hold_after_release: got x=%0d fs=%b expected 799/0", a_x, a_frame_start);
    end
    cycle(1'b1, 1'b1);
    tests++;
    if (a_x !== 10'd0 || a_y !== 10'd0 || a_frame_count !== 10'd0) begin
      failed++; $display("FAIL first_pixel: got x=%0d y=%0d fc=%0d expected 0/0/0", a_x, a_y, a_frame_count);
    end
    tests++;
    if ({a_frame_start, a_line_start, a_active} !== 3'b111) begin
      failed++; $display("FAIL first_flags: got %b expected 111", {a_frame_start, a_line_start, a_active});
    end
  endtask

  task automatic test_line();
    int ls_cnt = 0, ls_bad = 0, hs_cnt = 0, hs_bad = 0, act_cnt = 0, act_bad = 0, bhs_cnt = 0, bhs_bad = 0;
    cycle(1'b0, 1'b1);
    for (int i = 1; i <= 1600; i++) begin
      cycle(1'b1, 1'b1);
      if (a_line_start === 1'b1) begin
        ls_cnt++;
        if (i != 1 && i != 801) ls_bad++;
      end
      if (i <= 800) begin
        if (a_hsync === 1'b0) begin hs_cnt++; if (a_x < 10'd656 || a_x > 10'd751) hs_bad++; end
        if (a_active === 1'b1) begin act_cnt++; if (a_x > 10'd639) act_bad++; end
        if (b_hsync === 1'b1) begin bhs_cnt++; if (b_x < 10'd656 || b_x > 10'd751) bhs_bad++; end
      end
      if (i == 800) begin
        tests++;
        if (a_x !== 10'd799 || a_y !== 10'd0) begin
          failed++; $display("FAIL line_end: got %0d/%0d expected 799/0", a_x, a_y);
        end
      end
      if (i == 801) begin
        tests++;
        if (a_x !== 10'd0 || a_y !== 10'd1) begin
          failed++; $display("FAIL line_wrap: got %0d/%0d expected 0/1", a_x, a_y);
        end
      end
    end
    tests++;
    if (ls_cnt != 2 || ls_bad != 0) begin
      failed++; $display("FAIL line_start_count: got %0d (misplaced %0d) expected 2 (0)", ls_cnt, ls_bad);
    end
    tests++;
    if (hs_cnt != 96 || hs_bad != 0) begin
      failed++; $display("FAIL hsync_width_a: got %0d (out of range %0d) expected 96 (0)", hs_cnt, hs_bad);
    end
    tests++;
    if (act_cnt != 640 || act_bad != 0) begin
      failed++; $display("FAIL active_width: got %0d (out of range %0d) expected 640 (0)", act_cnt, act_bad);
    end
    tests++;
    if (bhs_cnt != 96 || bhs_bad != 0) begin
      failed++; $display("FAIL hsync_width_b: got %0d (out of range %0d) expected 96 (0)", bhs_cnt, bhs_bad);
    end
  endtask

  task automatic test_frames();
    int fs_cnt = 0, fs_bad = 0, vs_cnt = 0, vs_bad = 0, act_bad = 0, vs_move_bad = 0;
    logic prev_vs;
    cycle(1'b0, 1'b1);
    prev_vs = c_vsync;
    for (int i = 1; i <= 384; i++) begin
      cycle(1'b1, 1'b1);
      if (c_frame_start === 1'b1) begin
        fs_cnt++;
        if (i != 1 && i != 193) fs_bad++;
      end
      if (i == 1 || i == 193) begin
        tests++;
        if (c_frame_count !== ((i == 1) ? 10'd0 : 10'd1)) begin
          failed++; $display("FAIL frame_count_at_%0d: got %0d expected %0d", i, c_frame_count, (i == 1) ? 0 : 1);
        end
      end
      if (c_vsync === 1'b0) begin vs_cnt++; if (c_y != 10'd8 && c_y != 10'd9) vs_bad++; end
      if (c_active === 1'b1 && c_y >= 10'd6) act_bad++;
      if (c_vsync !== prev_vs && c_x !== 10'd0) vs_move_bad++;
      prev_vs = c_vsync;
    end
    tests++;
    if (fs_cnt != 2 || fs_bad != 0) begin
      failed++; $display("FAIL frame_start_count: got %0d (misplaced %0d) expected 2 (0)", fs_cnt, fs_bad);
    end
    tests++;
    if (vs_cnt != 64 || vs_bad != 0) begin
      failed++; $display("FAIL vsync_width: got %0d (wrong line %0d) expected 64 (0)", vs_cnt, vs_bad);
    end
    tests++;
    if (act_bad != 0 || vs_move_bad != 0) begin
      failed++; $display("FAIL vblank_rules: got active_in_vblank=%0d vsync_off_x0=%0d expected 0/0", act_bad, vs_move_bad);
    end
  endtask

  task automatic test_enable_toggle();
    int ls_cnt = 0;
    int first_wrap = -1;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 3200; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (a_line_start === 1'b1) ls_cnt++;
      if (i >= 2 && first_wrap < 0 && a_x === 10'd0) first_wrap = i;
    end
    tests++;
    if (ls_cnt != 4) begin
      failed++; $display("FAIL toggle_line_start: got %0d clocks expected 4", ls_cnt);
    end
    tests++;
    if (first_wrap != 1600) begin
      failed++; $display("FAIL toggle_line_period: got %0d expected 1600", first_wrap);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b1);
    for (int i = 1; i <= 301; i++) cycle(1'b1, 1'b1);
    tests++;
    if (a_x !== 10'd300 || c_frame_count !== 10'd1) begin
      failed++; $display("FAIL mid_position: got a_x=%0d c_fc=%0d expected 300/1", a_x, c_frame_count);
    end
    cycle(1'b0, 1'b1);
    tests++;
    if (a_x !== 10'd799 || a_y !== 10'd524 || c_x !== 10'd15 || c_y !== 10'd11) begin
      failed++; $display("FAIL mid_reset_xy: got a=%0d/%0d c=%0d/%0d expected 799/524 15/11", a_x, a_y, c_x, c_y);
    end
    tests++;
    if ({a_hsync, a_vsync, a_active, a_active_d, a_hsync_d, a_vsync_d, c_vsync} !== 7'b1100111) begin
      failed++; $display("FAIL mid_reset_sync: got %b expected 1100111",
                         {a_hsync, a_vsync, a_active, a_active_d, a_hsync_d, a_vsync_d, c_vsync});
    end
    cycle(1'b1, 1'b1);
    tests++;
    if (a_frame_start !== 1'b1 || a_frame_count !== 10'd0 || c_frame_start !== 1'b1 || c_frame_count !== 10'd0) begin
      failed++; $display("FAIL mid_reset_restart: got a_fs=%b a_fc=%0d c_fs=%b c_fc=%0d expected 1/0/1/0",
                         a_frame_start, a_frame_count, c_frame_start, c_frame_count);
    end
  endtask

  task automatic test_pipe_delay();
    int rise_hs = -1, rise_hd = -1, fall_ad = -1;
    logic prev_hs, prev_hd, prev_ad;
    cycle(1'b0, 1'b1);
    prev_hs = b_hsync; prev_hd = b_hsync_d; prev_ad = a_hsync_d;
    for (int i = 1; i <= 800; i++) begin
      cycle(1'b1, 1'b1);
      if (b_hsync === 1'b1 && prev_hs === 1'b0 && rise_hs < 0) rise_hs = i;
      if (b_hsync_d === 1'b1 && prev_hd === 1'b0 && rise_hd < 0) rise_hd = i;
      if (a_hsync_d === 1'b0 && prev_ad === 1'b1 && fall_ad < 0) fall_ad = i;
      prev_hs = b_hsync; prev_hd = b_hsync_d; prev_ad = a_hsync_d;
    end
    tests++;
    if (rise_hs != 657) begin
      failed++; $display("FAIL b_hsync_rise: got cycle %0d expected 657", rise_hs);
    end
    tests++;
    if (rise_hd - rise_hs != 3) begin
      failed++; $display("FAIL b_hsync_d_lag: got %0d expected 3", rise_hd - rise_hs);
    end
    tests++;
    if (fall_ad != 659) begin
      failed++; $display("FAIL a_hsync_d_fall: got cycle %0d expected 659", fall_ad);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_enable_toggle();
    test_mid_reset();
    test_pipe_delay();
    #10;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
